// File: rtl/result_uart_tx.sv
// result_uart_tx: sends a 3-byte ASCII result message over 8N1 UART for each result code
module result_uart_tx #(
  parameter int          CLKS_PER_BIT  = 434,
  parameter logic [7:0]  MATCH_CHAR    = 8'h59,
  parameter logic [7:0]  NOTMATCH_CHAR = 8'h4E
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] UARTsend,
  output logic       UARTsendComplete,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, SEND, DONE, WAIT_OFF} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n, code, code_n;
  logic tx_n, busy_n, done_n, trig, last_cnt;
  logic [7:0] data;
  logic [9:0] frame;
  assign trig = UARTsend == 2'd1 || UARTsend == 2'd2;
  assign last_cnt = cnt == CW'(CLKS_PER_BIT - 1);
  assign data = byte_idx == 2'd0 ? (code == 2'd1 ? MATCH_CHAR : NOTMATCH_CHAR) :
                byte_idx == 2'd1 ? 8'h0D : 8'h0A;
  assign frame = {1'b1, data, 1'b0};
  // State and datapath registers; every output comes straight from a flop
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      code <= 2'd0;
      tx <= 1'b1;
      busy <= 1'b0;
      UARTsendComplete <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      code <= code_n;
      tx <= tx_n;
      busy <= busy_n;
      UARTsendComplete <= done_n;
    end
  end
  // Next-state logic: tx is precomputed for the bit that starts on the coming edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_idx;
    byte_n = byte_idx;
    code_n = code;
    tx_n = tx;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (trig) begin
        state_n = SEND;
        code_n = UARTsend;
        busy_n = 1'b1;
        tx_n = 1'b0;
        cnt_n = '0;
        bit_n = '0;
        byte_n = '0;
      end
      SEND: if (!last_cnt) cnt_n = cnt + 1'b1;
      else begin
        cnt_n = '0;
        if (bit_idx != 4'd9) begin
          bit_n = bit_idx + 4'd1;
          tx_n = frame[bit_idx + 4'd1];
        end else if (byte_idx != 2'd2) begin
          byte_n = byte_idx + 2'd1;
          bit_n = '0;
          tx_n = 1'b0;
        end else begin
          state_n = DONE;
          tx_n = 1'b1;
          done_n = 1'b1;
        end
      end
      DONE: begin
        state_n = WAIT_OFF;
        busy_n = 1'b0;
      end
      WAIT_OFF: if (!trig) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed checks of the result UART transmitter at 4 clocks per bit
module tb_result_uart_tx;
  localparam int CPB = 4;
  localparam int MSG = 30 * CPB;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] UARTsend = 2'd0;
  logic UARTsendComplete, tx, busy;
  int errors = 0, checks = 0;
  logic tx_a[700], busy_a[700], cmp_a[700];

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .UARTsend(UARTsend),
    .UARTsendComplete(UARTsendComplete), .tx(tx), .busy(busy)
  );

  always #5 clock = ~clock;

  // Record n cycles sampled on falling edges; optionally change the code or pulse reset
  task automatic record(input int n, input int chg_at, input logic [1:0] chg_code, input int rst_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      tx_a[c] = tx;
      busy_a[c] = busy;
      cmp_a[c] = UARTsendComplete;
      if (c == chg_at) UARTsend = chg_code;
      if (c == rst_at) begin
        reset = 1'b1;
        UARTsend = 2'd0;
      end else reset = 1'b0;
    end
  endtask

  function automatic logic [7:0] decode(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tx_a[k * 10 * CPB + (j + 1) * CPB + CPB / 2];
    return b;
  endfunction

  function automatic int wave_err(input logic [7:0] b0);
    int e = 0;
    logic [7:0] d;
    logic [9:0] f;
    for (int c = 0; c < MSG; c++) begin
      d = c / (10 * CPB) == 0 ? b0 : c / (10 * CPB) == 1 ? 8'h0D : 8'h0A;
      f = {1'b1, d, 1'b0};
      if (tx_a[c] !== f[(c % (10 * CPB)) / CPB]) e++;
    end
    return e;
  endfunction

  function automatic int count(input int from, input int to, input int sel);
    int s = 0;
    for (int c = from; c < to; c++) s += sel == 0 ? int'(tx_a[c] === 1'b0) : sel == 1 ? int'(busy_a[c] === 1'b1) : int'(cmp_a[c] === 1'b1);
    return s;
  endfunction

  task automatic idle_off();
    UARTsend = 2'd0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    UARTsend = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({tx, busy, UARTsendComplete} !== 3'b100) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: tx/busy/cmp=%b%b%b expected 100", i, tx, busy, UARTsendComplete);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_match();
    int w;
    record(123, -1, 2'd0, -1);
    checks++;
    if (tx_a[0] !== 1'b0) begin errors++; $display("FAIL match_start tx=%b expected 0", tx_a[0]); end
    checks++;
    if (decode(0) !== 8'h59) begin errors++; $display("FAIL match_byte0 got %h expected 59", decode(0)); end
    checks++;
    if (decode(1) !== 8'h0D) begin errors++; $display("FAIL match_byte1 got %h expected 0d", decode(1)); end
    checks++;
    if (decode(2) !== 8'h0A) begin errors++; $display("FAIL match_byte2 got %h expected 0a", decode(2)); end
    w = wave_err(8'h59);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL match_wave bad_cycles=%0d expected 0", w); end
    checks++;
    if (count(MSG, 123, 0) !== 0) begin errors++; $display("FAIL match_tx_idle low_cycles=%0d expected 0", count(MSG, 123, 0)); end
    checks++;
    if (count(0, 123, 1) !== MSG + 1) begin errors++; $display("FAIL match_busy cycles=%0d expected %0d", count(0, 123, 1), MSG + 1); end
    checks++;
    if (count(0, 123, 2) !== 1 || cmp_a[MSG] !== 1'b1) begin
      errors++;
      $display("FAIL match_pulse count=%0d at_%0d=%b expected 1 and 1", count(0, 123, 2), MSG, cmp_a[MSG]);
    end
    idle_off();
  endtask

  task automatic test_notmatch();
    int w;
    UARTsend = 2'd2;
    record(123, -1, 2'd0, -1);
    checks++;
    if ({decode(0), decode(1), decode(2)} !== 24'h4E0D0A) begin
      errors++;
      $display("FAIL notmatch_bytes got %h%h%h expected 4e0d0a", decode(0), decode(1), decode(2));
    end
    w = wave_err(8'h4E);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL notmatch_wave bad_cycles=%0d expected 0", w); end
    checks++;
    if (cmp_a[MSG] !== 1'b1) begin errors++; $display("FAIL notmatch_pulse got %b expected 1", cmp_a[MSG]); end
    idle_off();
  endtask

  task automatic test_no_double();
    UARTsend = 2'd1;
    record(MSG + 501, -1, 2'd0, -1);
    checks++;
    if (count(0, MSG + 501, 2) !== 1) begin errors++; $display("FAIL nodouble_pulses got %0d expected 1", count(0, MSG + 501, 2)); end
    checks++;
    if (count(MSG, MSG + 501, 0) !== 0) begin errors++; $display("FAIL nodouble_tx low_cycles=%0d expected 0", count(MSG, MSG + 501, 0)); end
    checks++;
    if (count(MSG + 1, MSG + 501, 1) !== 0) begin errors++; $display("FAIL nodouble_busy cycles=%0d expected 0", count(MSG + 1, MSG + 501, 1)); end
    UARTsend = 2'd0;
    repeat (2) @(negedge clock);
    UARTsend = 2'd2;
    record(123, 122, 2'd0, -1);
    checks++;
    if (decode(0) !== 8'h4E || wave_err(8'h4E) !== 0) begin
      errors++;
      $display("FAIL nodouble_resend byte0=%h bad_cycles=%0d expected 4e and 0", decode(0), wave_err(8'h4E));
    end
    idle_off();
  endtask

  task automatic test_mid_change();
    UARTsend = 2'd1;
    record(123, 50, 2'd2, -1);
    checks++;
    if ({decode(0), decode(1), decode(2)} !== 24'h590D0A || wave_err(8'h59) !== 0) begin
      errors++;
      $display("FAIL midchange_bytes got %h%h%h expected 590d0a", decode(0), decode(1), decode(2));
    end
    idle_off();
  endtask

  task automatic test_mid_reset();
    UARTsend = 2'd1;
    record(130, -1, 2'd0, 60);
    checks++;
    if (tx_a[61] !== 1'b1 || busy_a[61] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs tx=%b busy=%b expected 1 0", tx_a[61], busy_a[61]);
    end
    checks++;
    if (count(0, 130, 2) !== 0) begin errors++; $display("FAIL midreset_pulse got %0d expected 0", count(0, 130, 2)); end
    checks++;
    if (count(61, 130, 0) !== 0) begin errors++; $display("FAIL midreset_idle low_cycles=%0d expected 0", count(61, 130, 0)); end
    UARTsend = 2'd2;
    record(123, 122, 2'd0, -1);
    checks++;
    if (decode(0) !== 8'h4E || cmp_a[MSG] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_retrigger byte0=%h pulse=%b expected 4e 1", decode(0), cmp_a[MSG]);
    end
    idle_off();
  endtask

  task automatic test_reserved();
    UARTsend = 2'd3;
    record(100, -1, 2'd0, -1);
    checks++;
    if (count(0, 100, 0) !== 0 || count(0, 100, 1) !== 0 || count(0, 100, 2) !== 0) begin
      errors++;
      $display("FAIL reserved_quiet tx_low=%0d busy=%0d pulses=%0d expected 0 0 0", count(0, 100, 0), count(0, 100, 1), count(0, 100, 2));
    end
    idle_off();
  endtask

  initial begin
    test_reset();
    test_match();
    test_notmatch();
    test_no_double();
    test_mid_change();
    test_mid_reset();
    test_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
